// File: rtl/instr_q_pkg.sv
// instr_q_pkg: shared types and default sizing for the fetch-to-decode instruction queue
package instr_q_pkg;
  localparam int IQ_DEPTH = 8;
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH) + 1;
  typedef logic [IQ_PTR_W-1:0] t_iq_ptr;
  typedef logic [IQ_PTR_W-1:0] t_iq_occ;
  typedef struct packed {
    logic [15:0] simid;
    logic [31:0] instr;
  } t_instr_pkt;
  typedef struct packed {
    logic valid;
  } t_br_mispred_pkt;
  typedef struct packed {
    logic valid;
  } t_nuke_pkt;
endpackage

// File: rtl/instr_q_iq_ptr.sv
// iq_ptr: wrap-bit queue pointer with increment and synchronous clear
module iq_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  // clear wins over increment so a flush always lands at slot zero
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/instr_q.sv
// instr_q: in-order instruction queue decoupling fetch from decode, flushed on mispredict or nuke
module instr_q
  import instr_q_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_fe1,
  input  t_instr_pkt             instr_fe1,
  output logic                   decode_ready_de0,
  input  t_br_mispred_pkt        br_mispred_ex0,
  input  t_nuke_pkt              nuke_rb1,
  output logic                   valid_iq0,
  output t_instr_pkt             instr_iq0,
  input  logic                   decode_ready_iq0,
  output logic [$clog2(DEPTH):0] occ_iq0
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  logic [AW:0] rd_ptr, wr_ptr, occ, occ_next;
  logic flush, enq, deq, empty;
  t_instr_pkt mem [DEPTH];
  assign flush = br_mispred_ex0.valid | nuke_rb1.valid;
  assign empty = rd_ptr == wr_ptr;
  assign valid_iq0 = !empty;
  assign instr_iq0 = mem[rd_ptr[AW-1:0]];
  assign enq = valid_fe1 & decode_ready_de0 & !flush;
  assign deq = valid_iq0 & decode_ready_iq0 & !flush;
  assign occ_next = flush ? '0 : occ + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
  assign occ_iq0 = occ;
  iq_ptr #(.W(AW+1)) u_rd (.clk(clk), .reset(reset), .clr(flush), .inc(deq), .ptr(rd_ptr));
  iq_ptr #(.W(AW+1)) u_wr (.clk(clk), .reset(reset), .clr(flush), .inc(enq), .ptr(wr_ptr));
  // occupancy and ready are loaded from the same next-state value so ready is exact
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      occ <= '0;
      decode_ready_de0 <= 1'b1;
    end else begin
      occ <= occ_next;
      decode_ready_de0 <= occ_next < DEPTH_V;
    end
  // payload storage is never cleared; only the pointers define which entries are live
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr[AW-1:0]] <= instr_fe1;
`ifdef ASSERT
  logic full;
  assign full = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  a_no_enq_full: assert property (@(posedge clk) disable iff (reset) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) !(deq && empty));
  a_occ_match: assert property (@(posedge clk) disable iff (reset) occ == wr_ptr - rd_ptr);
  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    valid_iq0 && !decode_ready_iq0 && !flush |=> $stable(instr_iq0));
`endif
endmodule
